pong_collision_unit: RTL and testbench
======================================

# pong_collision_unit

Owns both paddles and closes the loop back to the game FSM. It converts the four paddle buttons into clamped paddle positions. It compares the FSM's ball position against the walls and paddles and returns the collision flags `coll_L`/`coll_T`/`coll_R`/`coll_B`, plus the scoring pair `outofbounds`/`whoscored`. It sits between the button inputs, the game FSM and the VGA renderer, which consumes `paddle1Y`/`paddle2Y`.

## Interface
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `BALL_SIZE`, 8: ball edge length.
- `PAD_L_X`, 16: left paddle left edge x.
- `PAD_R_X`, 616: right paddle left edge x.
- `PAD_THICK`, 8: paddle thickness in x.
- `PAD_STEP`, 4: pixels per paddle move.
- `MOVE_DIV`, 250000: clk cycles per paddle move tick.
- `CENTER_X`, 316: ball x reset position used by the FSM.
- `CENTER_Y`, 236: ball y reset position used by the FSM.
- `clk  in  1`: system clock; all state on posedge.
- `reset  in  1`: synchronous, active-high.
- `button0  in  1`: left paddle up, asynchronous.
- `button1  in  1`: left paddle down, asynchronous.
- `button2  in  1`: right paddle up, asynchronous.
- `button3  in  1`: right paddle down, asynchronous.
- `ballX  in  10`: ball top-left x from the FSM.
- `ballY  in  9`: ball top-left y from the FSM.
- `paddlewidth  in  6`: current paddle length in y, from the FSM.
- `paddle1Y  out  9`: left paddle top y.
- `paddle2Y  out  9`: right paddle top y.
- `coll_L  out  1`: ball touching the left paddle face.
- `coll_R  out  1`: ball touching the right paddle face.
- `coll_T  out  1`: ball at the top wall.
- `coll_B  out  1`: ball at the bottom wall.
- `outofbounds  out  1`: sticky flag; a point was scored.
- `whoscored  out  2`: `2'b01` = player 1 scored, `2'b10` = player 2 scored, `2'b00` = none.

## Operation
- **Button input:** each button passes through a 2-flop synchronizer before use.
- **Move tick:** a counter runs 0..MOVE_DIV-1 and wraps.
  - `tick` is asserted for one cycle when the counter equals MOVE_DIV-1.
- **Paddle movement:** on `tick`, each paddle updates independently from its synchronized up/down pair.
  - Up only: Y = max(Y - PAD_STEP, 0), computed without unsigned underflow.
  - Down only: Y = min(Y + PAD_STEP, SCREEN_H - paddlewidth).
  - Both or neither: hold.
- **Paddle width shrink:** if `paddlewidth` shrinks, no re-clamp is needed, because the lower limit only grows.
- **Vertical overlap term:** for a paddle at P, vov(P) = (ballY + BALL_SIZE > P) && (ballY < P + paddlewidth).
  - Compute at 10 bits to avoid overflow.
- **Collision flags,** registered each clk:
  - coll_T = (ballY == 0).
  - coll_B = (ballY + BALL_SIZE >= SCREEN_H).
  - coll_L = !oob && ballX >= PAD_L_X && ballX <= PAD_L_X + PAD_THICK && vov(paddle1Y).
  - coll_R = !oob && ballX + BALL_SIZE >= PAD_R_X && ballX + BALL_SIZE <= PAD_R_X + PAD_THICK && vov(paddle2Y).
- **Exit conditions:**
  - Left exit: ballX <= 2, or ballX >= SCREEN_W. The second case covers the 10-bit wrap from decrementing past 0.
  - Right exit: ballX + BALL_SIZE >= SCREEN_W - 2, checked only when ballX < SCREEN_W.
- **Scoring state machine,** states PLAY and SCORED:
  - PLAY -> SCORED on a left exit: `outofbounds`=1, `whoscored`=2'b10.
  - PLAY -> SCORED on a right exit: `outofbounds`=1, `whoscored`=2'b01.
  - SCORED: both outputs are held constant, and further exit conditions are ignored.
  - SCORED -> PLAY when ballX==CENTER_X and ballY==CENTER_Y: `outofbounds`=0, `whoscored`=2'b00.
- **Hold requirement:** `outofbounds` must stay high steadily until the FSM recenters the ball. The FSM debounces it over 500 ms.

## Timing
- **Reset values:**
  - `paddle1Y` = `paddle2Y` = (SCREEN_H - 40)/2 = 220.
  - All `coll_*` = 0.
  - `outofbounds` = 0, `whoscored` = 2'b00.
  - State PLAY.
  - Tick counter = 0.
  - Synchronizer flops = 0.
- **Reset mid-operation:** reset overrides everything in the same edge, including a SCORED state.
- **Collision and scoring latency:** all collision and scoring outputs are registered, with 1 clk latency from `ballX`/`ballY`/`paddle*Y`.
- **Button-to-move latency:** a button press reaches the paddle 2 clk after synchronization plus up to MOVE_DIV clk for the next tick.
- **Simultaneous events:**
  - coll_T and coll_L may assert together; the FSM gives T priority.
  - While SCORED, coll_L and coll_R are forced 0.
  - coll_T and coll_B still track ballY.
- **Exit-priority corner:** left and right exits cannot coincide. If the recenter match and an exit condition appear in the same cycle while in SCORED, recenter wins.

## Test plan
- **Reset:** assert reset for 1 clk -> paddle1Y=220, paddle2Y=220, outofbounds=0, whoscored=00, all coll_*=0.
- **Paddle clamping** (MOVE_DIV=4, paddlewidth=40):
  - Hold button0 for 60 ticks -> paddle1Y decrements by 4 per tick and stops at 0.
  - Hold button1 -> paddle1Y stops at 440.
  - Press button2+button3 together -> paddle2Y unchanged.
- **Left paddle hit:** paddle1Y=200, ballX=20, ballY=210 -> coll_L=1 one clk later.
  - ballY=250 (no overlap) -> coll_L=0.
- **Walls:** ballY=0 -> coll_T=1; ballY=472 -> coll_B=1; ballY=236 -> both 0.
- **Scoring:**
  - ballX sweeps 10 -> 2 -> outofbounds=1, whoscored=10.
  - Then ballX=1022 -> outputs unchanged.
  - ballX=316, ballY=236 -> outofbounds=0, whoscored=00.
  - ballX=630 -> outofbounds=1, whoscored=01.
- **Reset while SCORED:** reset -> outofbounds=0 and coll_L re-enables on the next hit.

Source files
------------

// File: rtl/pong_collision_if.sv
// Bus between the game FSM / button pins and the collision unit:
// ball and paddle geometry in, collision and scoring flags out.
interface pong_collision_if;
    logic       button0;
    logic       button1;
    logic       button2;
    logic       button3;
    logic [9:0] ballX;
    logic [8:0] ballY;
    logic [5:0] paddlewidth;
    logic [8:0] paddle1Y;
    logic [8:0] paddle2Y;
    logic       coll_L;
    logic       coll_R;
    logic       coll_T;
    logic       coll_B;
    logic       outofbounds;
    logic [1:0] whoscored;

    modport master (
        output button0, button1, button2, button3, ballX, ballY, paddlewidth,
        input  paddle1Y, paddle2Y, coll_L, coll_R, coll_T, coll_B, outofbounds, whoscored
    );

    modport slave (
        input  button0, button1, button2, button3, ballX, ballY, paddlewidth,
        output paddle1Y, paddle2Y, coll_L, coll_R, coll_T, coll_B, outofbounds, whoscored
    );
endinterface

// File: rtl/pong_collision_unit.sv
// Paddle ownership plus ball/wall/paddle collision detection and the
// sticky scoring flag that closes the loop back to the game FSM.
module pong_collision_unit #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BALL_SIZE = 8,
    parameter int PAD_L_X   = 16,
    parameter int PAD_R_X   = 616,
    parameter int PAD_THICK = 8,
    parameter int PAD_STEP  = 4,
    parameter int MOVE_DIV  = 250000,
    parameter int CENTER_X  = 316,
    parameter int CENTER_Y  = 236
) (
    input  logic            clk,
    input  logic            reset,
    pong_collision_if.slave bus
);
    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);

    localparam logic [10:0] K_SCR_W = 11'(SCREEN_W);
    localparam logic [10:0] K_SCR_H = 11'(SCREEN_H);
    localparam logic [10:0] K_BALL  = 11'(BALL_SIZE);
    localparam logic [10:0] K_PAD_L = 11'(PAD_L_X);
    localparam logic [10:0] K_PAD_R = 11'(PAD_R_X);
    localparam logic [10:0] K_THICK = 11'(PAD_THICK);
    localparam logic [10:0] K_CX    = 11'(CENTER_X);
    localparam logic [10:0] K_CY    = 11'(CENTER_Y);
    localparam logic [8:0]  PAD_RST = 9'((SCREEN_H - 40) / 2);
    localparam logic signed [11:0] S_STEP = $signed(12'(PAD_STEP));

    typedef enum logic {PLAY, SCORED} state_t;

    function automatic logic [8:0] clamp_up(input logic [8:0] y);
        logic signed [11:0] t;
        t = $signed({3'b000, y}) - S_STEP;
        return (t < 12'sd0) ? 9'd0 : 9'(t);
    endfunction

    function automatic logic [8:0] clamp_down(input logic [8:0] y, input logic [10:0] lim);
        logic signed [11:0] t;
        t = $signed({3'b000, y}) + S_STEP;
        return (t > $signed({1'b0, lim})) ? 9'(lim) : 9'(t);
    endfunction

    function automatic logic [8:0] next_paddle(input logic [8:0] y, input logic up,
                                               input logic dn, input logic [10:0] lim);
        case ({up, dn})
            2'b10:   return clamp_up(y);
            2'b01:   return clamp_down(y, lim);
            default: return y;
        endcase
    endfunction

    function automatic logic vov(input logic [10:0] by, input logic [10:0] pad,
                                 input logic [10:0] pw);
        return (by + K_BALL > pad) && (by < pad + pw);
    endfunction

    logic [3:0]       btn_p0, btn_p1;
    logic [CNT_W-1:0] cnt_p0;
    logic             tick_p0;
    logic [8:0]       pad1_p1, pad2_p1;
    logic             coll_l_p1, coll_r_p1, coll_t_p1, coll_b_p1;
    state_t           state_p1;
    logic             oob_p1;
    logic [1:0]       who_p1;

    logic [10:0] bx_p0, by_p0, pw_p0, lim_p0, pad1_w, pad2_w;
    logic        left_exit_p0, right_exit_p0, recenter_p0, scored_p0;

    // ---- stage p0: synchronizers, move tick, widened operands
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            cnt_p0 <= '0;
        end else begin
            btn_p0 <= {bus.button3, bus.button2, bus.button1, bus.button0};
            btn_p1 <= btn_p0;
            cnt_p0 <= tick_p0 ? '0 : cnt_p0 + 1'b1;
        end
    end

    assign tick_p0       = (cnt_p0 == CNT_LAST);
    assign bx_p0         = {1'b0, bus.ballX};
    assign by_p0         = {2'b00, bus.ballY};
    assign pw_p0         = {5'b00000, bus.paddlewidth};
    assign lim_p0        = K_SCR_H - pw_p0;
    assign pad1_w        = {2'b00, pad1_p1};
    assign pad2_w        = {2'b00, pad2_p1};
    // bx >= SCREEN_W catches the 10-bit wrap when the FSM steps left past 0
    assign left_exit_p0  = (bx_p0 <= 11'd2) || (bx_p0 >= K_SCR_W);
    assign right_exit_p0 = (bx_p0 < K_SCR_W) && (bx_p0 + K_BALL >= K_SCR_W - 11'd2);
    assign recenter_p0   = (bx_p0 == K_CX) && (by_p0 == K_CY);
    assign scored_p0     = (state_p1 == SCORED);

    // ---- stage p1: paddles, collision flags, scoring state
    always_ff @(posedge clk) begin
        if (reset) begin
            pad1_p1 <= PAD_RST;
            pad2_p1 <= PAD_RST;
        end else if (tick_p0) begin
            pad1_p1 <= next_paddle(pad1_p1, btn_p1[0], btn_p1[1], lim_p0);
            pad2_p1 <= next_paddle(pad2_p1, btn_p1[2], btn_p1[3], lim_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coll_l_p1 <= 1'b0;
            coll_r_p1 <= 1'b0;
            coll_t_p1 <= 1'b0;
            coll_b_p1 <= 1'b0;
        end else begin
            coll_t_p1 <= (by_p0 == 11'd0);
            coll_b_p1 <= (by_p0 + K_BALL >= K_SCR_H);
            coll_l_p1 <= !scored_p0 && (bx_p0 >= K_PAD_L) && (bx_p0 <= K_PAD_L + K_THICK)
                         && vov(by_p0, pad1_w, pw_p0);
            coll_r_p1 <= !scored_p0 && (bx_p0 + K_BALL >= K_PAD_R)
                         && (bx_p0 + K_BALL <= K_PAD_R + K_THICK) && vov(by_p0, pad2_w, pw_p0);
        end
    end

    // outofbounds is held steadily in SCORED so the FSM can debounce it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= PLAY;
            oob_p1   <= 1'b0;
            who_p1   <= 2'b00;
        end else begin
            case (state_p1)
                PLAY: begin
                    if (left_exit_p0) begin
                        state_p1 <= SCORED;
                        oob_p1   <= 1'b1;
                        who_p1   <= 2'b10;
                    end else if (right_exit_p0) begin
                        state_p1 <= SCORED;
                        oob_p1   <= 1'b1;
                        who_p1   <= 2'b01;
                    end
                end
                SCORED: begin
                    if (recenter_p0) begin
                        state_p1 <= PLAY;
                        oob_p1   <= 1'b0;
                        who_p1   <= 2'b00;
                    end
                end
            endcase
        end
    end

    assign bus.paddle1Y    = pad1_p1;
    assign bus.paddle2Y    = pad2_p1;
    assign bus.coll_L      = coll_l_p1;
    assign bus.coll_R      = coll_r_p1;
    assign bus.coll_T      = coll_t_p1;
    assign bus.coll_B      = coll_b_p1;
    assign bus.outofbounds = oob_p1;
    assign bus.whoscored   = who_p1;
endmodule

// File: tb/tb_pong_collision_unit.sv
// Randomized bench for pong_collision_unit against an integer-arithmetic
// model of paddles, collisions and scoring, plus directed literal checks.
module tb_pong_collision_unit;
    localparam int MD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pong_collision_if bus();

    pong_collision_unit #(.MOVE_DIV(MD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int       p1, p2, cnt, who;
        bit       scored, cl, cr, ct, cb;
        bit [3:0] d1, d2;
    } mstate_t;

    mstate_t m;
    bit      m_valid = 1'b0;

    function automatic bit vov(int by, int p, int pw);
        return (by + 8 > p) && (by < p + pw);
    endfunction

    function automatic int move(int y, bit up, bit dn, int lim);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > lim) ? lim : y + 4;
        return y;
    endfunction

    function automatic mstate_t model_next(mstate_t s, bit rst, int bx, int by, int pw,
                                           bit [3:0] btn);
        mstate_t n = s;
        bit lx, rx;
        if (rst) begin
            n.p1 = 220; n.p2 = 220; n.cnt = 0; n.who = 0; n.scored = 1'b0;
            n.cl = 1'b0; n.cr = 1'b0; n.ct = 1'b0; n.cb = 1'b0; n.d1 = '0; n.d2 = '0;
            return n;
        end
        n.ct = (by == 0);
        n.cb = (by + 8 >= 480);
        n.cl = !s.scored && bx >= 16 && bx <= 24 && vov(by, s.p1, pw);
        n.cr = !s.scored && bx + 8 >= 616 && bx + 8 <= 624 && vov(by, s.p2, pw);
        lx = (bx <= 2) || (bx >= 640);
        rx = (bx < 640) && (bx + 8 >= 638);
        if (s.scored) begin
            if (bx == 316 && by == 236) begin n.scored = 1'b0; n.who = 0; end
        end else if (lx) begin
            n.scored = 1'b1; n.who = 2;
        end else if (rx) begin
            n.scored = 1'b1; n.who = 1;
        end
        n.d1 = btn;
        n.d2 = s.d1;
        if (s.cnt == MD - 1) begin
            n.cnt = 0;
            n.p1  = move(s.p1, s.d2[0], s.d2[1], 480 - pw);
            n.p2  = move(s.p2, s.d2[2], s.d2[3], 480 - pw);
        end else begin
            n.cnt = s.cnt + 1;
        end
        return n;
    endfunction

    // model advances on the same edge as the DUT, from the pre-edge inputs
    initial forever begin
        @(posedge clk);
        m = model_next(m, reset, int'(bus.ballX), int'(bus.ballY), int'(bus.paddlewidth),
                       {bus.button3, bus.button2, bus.button1, bus.button0});
        if (reset) m_valid = 1'b1;
    end

    initial forever begin
        logic [24:0] exp_v, act_v;
        @(negedge clk);
        if (m_valid) begin
            exp_v = {9'(m.p1), 9'(m.p2), m.cl, m.cr, m.ct, m.cb, m.scored, 2'(m.who)};
            act_v = {bus.paddle1Y, bus.paddle2Y, bus.coll_L, bus.coll_R, bus.coll_T,
                     bus.coll_B, bus.outofbounds, bus.whoscored};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got p1=%0d p2=%0d LRTB=%b oob=%b who=%b required p1=%0d p2=%0d LRTB=%b oob=%b who=%b",
                         $time, act_v[24:16], act_v[15:7], act_v[6:3], act_v[2], act_v[1:0],
                         exp_v[24:16], exp_v[15:7], exp_v[6:3], exp_v[2], exp_v[1:0]);
            end
        end
    end

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic set_ball(int x, int y);
        bus.ballX = 10'(x);
        bus.ballY = 9'(y);
    endtask

    task automatic set_btn(bit [3:0] b);
        {bus.button3, bus.button2, bus.button1, bus.button0} = b;
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int bx, by;
        set_ball(100, 100);
        bus.paddlewidth = 6'd40;
        set_btn(4'b0000);
        reset = 1'b1;
        cycles(2);
        check("rst_paddle1Y", int'(bus.paddle1Y), 220);
        check("rst_paddle2Y", int'(bus.paddle2Y), 220);
        check("rst_outofbounds", int'(bus.outofbounds), 0);
        check("rst_whoscored", int'(bus.whoscored), 0);
        check("rst_coll", int'({bus.coll_L, bus.coll_R, bus.coll_T, bus.coll_B}), 0);
        reset = 1'b0;

        set_btn(4'b0001);
        cycles(260);
        check("clamp_top", int'(bus.paddle1Y), 0);
        check("model_clamp_top", m.p1, 0);
        set_btn(4'b0010);
        cycles(480);
        check("clamp_bottom", int'(bus.paddle1Y), 440);
        check("model_clamp_bottom", m.p1, 440);
        set_btn(4'b1100);
        cycles(40);
        check("both_hold", int'(bus.paddle2Y), 220);
        set_btn(4'b0000);
        cycles(4);

        set_ball(20, 450); cycles(1);
        check("left_hit", int'(bus.coll_L), 1);
        set_ball(20, 400); cycles(1);
        check("left_miss", int'(bus.coll_L), 0);

        set_ball(100, 0); cycles(1);
        check("wall_top", int'(bus.coll_T), 1);
        set_ball(100, 472); cycles(1);
        check("wall_bottom", int'(bus.coll_B), 1);
        set_ball(100, 236); cycles(1);
        check("wall_none", int'({bus.coll_T, bus.coll_B}), 0);

        for (int x = 10; x >= 3; x--) begin
            set_ball(x, 100); cycles(1);
        end
        check("no_score_at_3", int'(bus.outofbounds), 0);
        set_ball(2, 100); cycles(1);
        check("left_exit_oob", int'(bus.outofbounds), 1);
        check("left_exit_who", int'(bus.whoscored), 2);
        set_ball(1022, 100); cycles(1);
        check("scored_hold_oob", int'(bus.outofbounds), 1);
        check("scored_hold_who", int'(bus.whoscored), 2);
        set_ball(20, 450); cycles(1);
        check("scored_no_coll_L", int'(bus.coll_L), 0);
        set_ball(316, 236); cycles(1);
        check("recenter_oob", int'(bus.outofbounds), 0);
        check("recenter_who", int'(bus.whoscored), 0);
        set_ball(630, 100); cycles(1);
        check("right_exit_oob", int'(bus.outofbounds), 1);
        check("right_exit_who", int'(bus.whoscored), 1);

        reset = 1'b1; cycles(1);
        check("rst_scored_oob", int'(bus.outofbounds), 0);
        reset = 1'b0;
        set_ball(20, 230); cycles(1);
        check("post_rst_left_hit", int'(bus.coll_L), 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) set_btn(4'($urandom_range(0, 15)));
            case ($urandom_range(0, 5))
                0:       bx = $urandom_range(0, 1023);
                1:       bx = $urandom_range(0, 30);
                2:       bx = $urandom_range(600, 645);
                3:       bx = 316;
                default: bx = $urandom_range(10, 40);
            endcase
            case ($urandom_range(0, 4))
                0:       by = 236;
                1:       by = ($urandom_range(0, 1) == 0) ? 0 : 472;
                2:       by = $urandom_range(0, 511);
                default: by = $urandom_range(0, 480);
            endcase
            set_ball(bx, by);
            if ($urandom_range(0, 199) == 0) bus.paddlewidth = 6'($urandom_range(8, 63));
            reset = ($urandom_range(0, 499) == 0);
            cycles(1);
        end
        reset = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
